// File: rtl/dtw_result_packer.sv
// Collects DTW results for one query session, tracks the minimum score and its
// position, then writes a 3-word record {hdr, best_score, best_pos} into the output FIFO.
module dtw_result_packer #(
  parameter int          SCORE_W = 32,
  parameter int          POS_W   = 32,
  parameter int          ID_W    = 8,
  parameter int          CNT_W   = 16,
  parameter logic [7:0]  MAGIC   = 8'hA5
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               q_start,
  input  logic [ID_W-1:0]    q_id,
  input  logic               q_done,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [SCORE_W-1:0] res_score,
  input  logic [POS_W-1:0]   res_pos,
  output logic               fifo_wren,
  output logic [31:0]        fifo_din,
  input  logic               fifo_full,
  output logic               busy,
  output logic               proto_err,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         word_idx;
  logic [CNT_W-1:0]   count;
  logic [SCORE_W-1:0] best_score;
  logic [POS_W-1:0]   best_pos;
  logic [ID_W-1:0]    qid;
  logic               accept;

  // Handshake: a result transfers on a cycle where res_valid && res_ready are both
  // high at the rising edge; res_ready is high only in COLLECT. The FIFO side is a
  // plain write strobe: a word is written on every cycle with fifo_wren high, and
  // fifo_wren is withheld while fifo_full is high so fifo_din/word_idx stay put.
  assign res_ready = (state == COLLECT);
  assign accept    = res_valid && res_ready;
  assign fifo_wren = (state == EMIT) && !fifo_full;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    fifo_din = 32'd0;
    if (state == EMIT) begin
      case (word_idx)
        2'd0:    fifo_din = {MAGIC, qid, count};
        2'd1:    fifo_din = 32'(best_score);
        2'd2:    fifo_din = 32'(best_pos);
        default: fifo_din = 32'd0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      word_idx   <= 2'd0;
      count      <= '0;
      best_score <= '1;
      best_pos   <= '0;
      qid        <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (q_start) begin
            state      <= COLLECT;
            qid        <= q_id;
            count      <= '0;
            best_score <= '1;
            best_pos   <= '0;
          end
        end
        COLLECT: begin
          if (q_start) proto_err <= 1'b1;
          if (accept) begin
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            // Strict compare keeps the earliest position on ties.
            if (res_score < best_score) begin
              best_score <= res_score;
              best_pos   <= res_pos;
            end
          end
          if (q_done) begin
            state    <= EMIT;
            word_idx <= 2'd0;
          end
        end
        EMIT: begin
          if (q_start) proto_err <= 1'b1;
          if (fifo_wren) begin
            if (word_idx == 2'd2) begin
              state    <= IDLE;
              word_idx <= 2'd0;
            end else begin
              word_idx <= word_idx + 2'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          word_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_result_packer.sv
// Directed bench for dtw_result_packer: record contents, backpressure, empty
// sessions, same-cycle result/done, protocol errors and asynchronous reset.
module tb_dtw_result_packer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        q_start = 1'b0;
  logic [7:0]  q_id = 8'd0;
  logic        q_done = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_score = 32'd0;
  logic [31:0] res_pos = 32'd0;
  logic        fifo_wren;
  logic [31:0] fifo_din;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        proto_err;
  logic [1:0]  dbg_state;

  int tests = 0;
  int failed = 0;
  logic [31:0] rec [0:2];
  int got;

  dtw_result_packer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .q_start(q_start), .q_id(q_id), .q_done(q_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_pos(res_pos),
    .fifo_wren(fifo_wren), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .busy(busy), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_session(input logic [7:0] id);
    q_start = 1'b1;
    q_id    = id;
    tick();
    q_start = 1'b0;
  endtask

  task automatic send_result(input logic [31:0] s, input logic [31:0] p);
    res_valid = 1'b1;
    res_score = s;
    res_pos   = p;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic done_pulse();
    q_done = 1'b1;
    tick();
    q_done = 1'b0;
  endtask

  // Gathers the three record words, bounded by a cycle budget.
  task automatic get_record(input string tag, input int budget);
    rec[0] = 32'hDEADBEEF; rec[1] = 32'hDEADBEEF; rec[2] = 32'hDEADBEEF;
    got = 0;
    for (int c = 0; c < budget && got < 3; c++) begin
      if (fifo_wren) begin
        rec[got] = fifo_din;
        got++;
      end
      tick();
    end
    check({tag, "_words"}, got, 32'd3);
    check({tag, "_idle_wren"}, {31'd0, fifo_wren}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", {31'd0, res_ready}, 32'd0);
    check("rst_wren", {31'd0, fifo_wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_din", fifo_din, 32'd0);
    check("rst_perr", {31'd0, proto_err}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    // 1: basic record, no backpressure, consecutive writes
    start_session(8'h07);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready", {31'd0, res_ready}, 32'd1);
    send_result(32'd50, 32'd10);
    send_result(32'd20, 32'd11);
    send_result(32'd20, 32'd12);
    send_result(32'd35, 32'd13);
    check("t1_ready_pre_done", {31'd0, res_ready}, 32'd1);
    done_pulse();
    check("t1_ready_emit", {31'd0, res_ready}, 32'd0);
    check("t1_w0_wren", {31'd0, fifo_wren}, 32'd1);
    check("t1_w0", fifo_din, 32'hA5070004);
    tick();
    check("t1_w1_wren", {31'd0, fifo_wren}, 32'd1);
    check("t1_w1", fifo_din, 32'h00000014);
    tick();
    check("t1_w2_wren", {31'd0, fifo_wren}, 32'd1);
    check("t1_w2", fifo_din, 32'h0000000B);
    tick();
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_wren_end", {31'd0, fifo_wren}, 32'd0);
    check("t1_din_end", fifo_din, 32'd0);

    // 2: same session, FIFO full for 5 cycles after entering EMIT
    start_session(8'h07);
    send_result(32'd50, 32'd10);
    send_result(32'd20, 32'd11);
    send_result(32'd20, 32'd12);
    send_result(32'd35, 32'd13);
    fifo_full = 1'b1;
    done_pulse();
    for (int i = 0; i < 5; i++) begin
      check("t2_full_wren", {31'd0, fifo_wren}, 32'd0);
      check("t2_full_din", fifo_din, 32'hA5070004);
      check("t2_full_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    get_record("t2", 20);
    check("t2_w0", rec[0], 32'hA5070004);
    check("t2_w1", rec[1], 32'h00000014);
    check("t2_w2", rec[2], 32'h0000000B);

    // 3: zero-result session
    start_session(8'h01);
    done_pulse();
    get_record("t3", 20);
    check("t3_w0", rec[0], 32'hA5010000);
    check("t3_w1", rec[1], 32'hFFFFFFFF);
    check("t3_w2", rec[2], 32'h00000000);

    // 4: result accepted in the same cycle as q_done
    start_session(8'h02);
    send_result(32'd10, 32'd5);
    res_valid = 1'b1; res_score = 32'd3; res_pos = 32'd99;
    done_pulse();
    res_valid = 1'b0;
    #1;
    get_record("t4", 20);
    check("t4_w0", rec[0], 32'hA5020002);
    check("t4_w1", rec[1], 32'h00000003);
    check("t4_w2", rec[2], 32'h00000063);

    // 5: q_start during COLLECT and EMIT flags proto_err, record unaffected
    check("t5_perr_before", {31'd0, proto_err}, 32'd0);
    start_session(8'h04);
    start_session(8'h09);
    check("t5_perr_collect", {31'd0, proto_err}, 32'd1);
    send_result(32'd7, 32'd1);
    fifo_full = 1'b1;
    done_pulse();
    start_session(8'h0A);
    fifo_full = 1'b0;
    #1;
    check("t5_din_after_qs", fifo_din, 32'hA5040001);
    get_record("t5", 20);
    check("t5_w0", rec[0], 32'hA5040001);
    check("t5_w1", rec[1], 32'h00000007);
    check("t5_w2", rec[2], 32'h00000001);
    tick();
    check("t5_perr_sticky", {31'd0, proto_err}, 32'd1);

    // 6: async reset mid-EMIT after word 0
    start_session(8'h05);
    send_result(32'd1, 32'd2);
    done_pulse();
    check("t6_w0", fifo_din, 32'hA5050001);
    tick();
    check("t6_w1_pending", {31'd0, fifo_wren}, 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_rst_wren", {31'd0, fifo_wren}, 32'd0);
    check("t6_rst_din", fifo_din, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {31'd0, res_ready}, 32'd0);
    check("t6_rst_perr", {31'd0, proto_err}, 32'd0);
    check("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_no_wren", {31'd0, fifo_wren}, 32'd0);
    end
    start_session(8'h06);
    done_pulse();
    get_record("t6b", 20);
    check("t6b_w0", rec[0], 32'hA5060000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
